// File: rtl/mavg_threshold_detector_pkg.sv
// Shared types and constants for the moving-average threshold detector.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package mavg_threshold_detector_pkg;

  // Datapath widths
  localparam int AVG_W  = 8;
  localparam int TS_W   = 7;
  localparam int HOLD_W = 4;
  localparam int EVT_W  = 16;

  // Event word layout: {rising, timestamp, average}
  localparam int EVT_DIR_POS = 15;
  localparam int EVT_TS_MSB  = 14;
  localparam int EVT_TS_LSB  = 8;
  localparam int EVT_AVG_MSB = 7;
  localparam int EVT_AVG_LSB = 0;

  // Detector state; encodings are visible on state_o
  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_PEND_HI = 2'd1,
    ST_HIGH    = 2'd2,
    ST_PEND_LO = 2'd3
  } state_e;

  // A hold of zero behaves like a hold of one (switch on the first qualifying sample)
  function automatic logic [HOLD_W-1:0] eff_hold(input logic [HOLD_W-1:0] h);
    return (h == '0) ? HOLD_W'(1) : h;
  endfunction

endpackage

// File: rtl/mavg_event_fifo.sv
// Event queue: DEPTH-entry first-word-fall-through FIFO for detector events.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: in_rdy drops only when full and not popping; head holds while out_rdy is low.
module mavg_event_fifo
  import mavg_threshold_detector_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = EVT_W
) (
  input  logic             system1000,
  input  logic             system1000_rstn,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic           push, pop;

  // Handshake decode; a full queue still accepts when the head leaves the same cycle
  always_comb begin
    out_vld = (cnt_q != '0);
    pop     = out_vld & out_rdy;
    in_rdy  = (cnt_q != (AW+1)'(DEPTH)) | pop;
    push    = in_vld & in_rdy;
    out_dat = out_vld ? mem_q[rd_ptr_q] : '0;
  end

  // Next-state for pointers, occupancy and storage; pointers wrap naturally (DEPTH is 2^AW)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset empties the queue at once
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/mavg_threshold_detector.sv
// Hysteresis threshold detector on a 4-tap average, emitting timestamped crossing events.
// Latency: avg_o/state_o one cycle after the sample; events visible one cycle after their sample.
// Backpressure: events queue in EVT_DEPTH entries; a push into a full, non-popping queue is dropped and flagged sticky.
module mavg_threshold_detector
  import mavg_threshold_detector_pkg::*;
#(
  parameter int EVT_DEPTH = 4  // power of two, 2..16
) (
  input  logic                    system1000,
  input  logic                    system1000_rstn,
  input  logic signed [AVG_W-1:0] sum_i,
  input  logic                    sum_valid_i,
  input  logic signed [AVG_W-1:0] thr_hi_i,
  input  logic signed [AVG_W-1:0] thr_lo_i,
  input  logic [HOLD_W-1:0]       hold_i,
  output logic signed [AVG_W-1:0] avg_o,
  output logic [1:0]              state_o,
  output logic                    evt_valid_o,
  input  logic                    evt_ready_i,
  output logic [EVT_W-1:0]        evt_data_o,
  output logic                    overflow_o
);

  logic signed [AVG_W-1:0] avg;
  logic signed [AVG_W-1:0] avg_q, avg_d;
  logic [TS_W-1:0]         ts_q, ts_d;
  state_e                  state_q, state_d;
  logic [HOLD_W-1:0]       cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic [HOLD_W:0]         cnt_inc, hold_eff;
  logic                    evt_fire, evt_rising;
  logic [EVT_W-1:0]        evt_dat;
  logic                    fifo_in_rdy;

  // Sum of four taps divided by four, rounding toward minus infinity
  assign avg = sum_i >>> 2;

  // Qualify/hysteresis FSM; LOW and HIGH hold a zero count so they share the pending arms
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    evt_fire   = 1'b0;
    evt_rising = 1'b0;
    cnt_inc    = {1'b0, cnt_q} + (HOLD_W+1)'(1);
    hold_eff   = {1'b0, eff_hold(hold_i)};
    if (sum_valid_i) begin
      case (state_q)
        ST_LOW, ST_PEND_HI: begin
          if (avg > thr_hi_i) begin
            if (cnt_inc >= hold_eff) begin
              state_d    = ST_HIGH;
              cnt_d      = '0;
              evt_fire   = 1'b1;
              evt_rising = 1'b1;
            end else begin
              state_d = ST_PEND_HI;
              cnt_d   = cnt_inc[HOLD_W-1:0];
            end
          end else begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end
        end
        ST_HIGH, ST_PEND_LO: begin
          if (avg < thr_lo_i) begin
            if (cnt_inc >= hold_eff) begin
              state_d  = ST_LOW;
              cnt_d    = '0;
              evt_fire = 1'b1;
            end else begin
              state_d = ST_PEND_LO;
              cnt_d   = cnt_inc[HOLD_W-1:0];
            end
          end else begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Average/timestamp capture, event word assembly and sticky drop flag
  always_comb begin
    avg_d   = sum_valid_i ? avg : avg_q;
    ts_d    = sum_valid_i ? ts_q + TS_W'(1) : ts_q;
    evt_dat = '0;
    evt_dat[EVT_DIR_POS]             = evt_rising;
    evt_dat[EVT_TS_MSB:EVT_TS_LSB]   = ts_q;
    evt_dat[EVT_AVG_MSB:EVT_AVG_LSB] = avg;
    ovf_d   = ovf_q | (evt_fire & ~fifo_in_rdy);
  end

  // State registers
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      avg_q   <= '0;
      ts_q    <= '0;
      state_q <= ST_LOW;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      avg_q   <= avg_d;
      ts_q    <= ts_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  mavg_event_fifo #(
    .DEPTH (EVT_DEPTH),
    .WIDTH (EVT_W)
  ) u_evt_fifo (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .in_vld          (evt_fire),
    .in_rdy          (fifo_in_rdy),
    .in_dat          (evt_dat),
    .out_vld         (evt_valid_o),
    .out_rdy         (evt_ready_i),
    .out_dat         (evt_data_o)
  );

  assign avg_o      = avg_q;
  assign state_o    = state_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_mavg_threshold_detector.sv
// Bench for mavg_threshold_detector: directed scenarios plus random traffic against a reference model.
// Latency: outputs compared one cycle after each driven sample.
// Backpressure: evt_ready_i driven low/high/random to exercise queue fill, overflow and drain.
module tb_mavg_threshold_detector;

  localparam int DEPTH = 4;

  logic              system1000 = 1'b0;
  logic              system1000_rstn;
  logic signed [7:0] sum_i;
  logic              sum_valid_i;
  logic signed [7:0] thr_hi_i;
  logic signed [7:0] thr_lo_i;
  logic [3:0]        hold_i;
  logic signed [7:0] avg_o;
  logic [1:0]        state_o;
  logic              evt_valid_o;
  logic              evt_ready_i;
  logic [15:0]       evt_data_o;
  logic              overflow_o;

  always #5 system1000 = ~system1000;

  mavg_threshold_detector #(.EVT_DEPTH(DEPTH)) dut (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .sum_i           (sum_i),
    .sum_valid_i     (sum_valid_i),
    .thr_hi_i        (thr_hi_i),
    .thr_lo_i        (thr_lo_i),
    .hold_i          (hold_i),
    .avg_o           (avg_o),
    .state_o         (state_o),
    .evt_valid_o     (evt_valid_o),
    .evt_ready_i     (evt_ready_i),
    .evt_data_o      (evt_data_o),
    .overflow_o      (overflow_o)
  );

  int n_chk = 0;
  int n_err = 0;

  // Expected queue contents, head first
  logic [15:0] sb[$];
  logic [15:0] mon_tmp;

  // Reference model: above = output side, streak = consecutive qualifying samples
  bit       m_above;
  int       m_streak;
  int       m_ts;
  logic [7:0] m_avg;
  bit       m_ovf;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int div4_floor(input int a);
    if (a >= 0) return a / 4;
    return -((-a + 3) / 4);
  endfunction

  function automatic logic [1:0] model_state();
    if (!m_above) return (m_streak > 0) ? 2'd1 : 2'd0;
    return (m_streak > 0) ? 2'd3 : 2'd2;
  endfunction

  // One cycle: check outputs from prior edges, advance model, drive new inputs
  task automatic step(input bit v, input int s, input bit r);
    int a, h, thi, tlo;
    bit pop, qual;
    logic [15:0] e;
    chk("avg_o", {8'h00, avg_o}, {8'h00, m_avg});
    chk("state_o", {14'h0, state_o}, {14'h0, model_state()});
    chk("overflow_o", {15'h0, overflow_o}, {15'h0, m_ovf});
    chk("evt_valid_o", {15'h0, evt_valid_o}, {15'h0, sb.size() != 0});
    pop = r && (sb.size() != 0);
    if (v) begin
      a   = div4_floor(s);
      h   = (hold_i == 0) ? 1 : int'(hold_i);
      thi = thr_hi_i;
      tlo = thr_lo_i;
      qual = m_above ? (a < tlo) : (a > thi);
      if (qual) begin
        m_streak++;
        if (m_streak >= h) begin
          e = {!m_above, 7'(m_ts), 8'(a)};
          m_above  = !m_above;
          m_streak = 0;
          if (sb.size() < DEPTH || pop) sb.push_back(e);
          else m_ovf = 1'b1;
        end
      end else begin
        m_streak = 0;
      end
      m_avg = 8'(a);
      m_ts  = (m_ts + 1) % 128;
    end
    sum_valid_i = v;
    sum_i       = 8'(s);
    evt_ready_i = r;
    @(posedge system1000);
    #1;
  endtask

  task automatic do_reset();
    sum_valid_i     = 1'b0;
    system1000_rstn = 1'b0;
    #1;
    chk("rst_avg", {8'h00, avg_o}, 16'h0000);
    chk("rst_state", {14'h0, state_o}, 16'h0000);
    chk("rst_evt_valid", {15'h0, evt_valid_o}, 16'h0000);
    chk("rst_evt_data", evt_data_o, 16'h0000);
    chk("rst_overflow", {15'h0, overflow_o}, 16'h0000);
    sb.delete();
    m_above = 1'b0; m_streak = 0; m_ts = 0; m_avg = 8'h00; m_ovf = 1'b0;
    repeat (2) @(posedge system1000);
    @(negedge system1000);
    system1000_rstn = 1'b1;
    @(posedge system1000);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) step(0, 0, 1);
    if (sb.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain_timeout: %0d events still expected", sb.size());
    end
    step(0, 0, 0);
  endtask

  // Monitor: whenever the head is valid it must match the expected head; pop on handshake
  initial begin
    forever begin
      @(negedge system1000);
      if (system1000_rstn === 1'b1 && evt_valid_o === 1'b1) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL evt_unexpected: got %h expected no event", evt_data_o);
        end else begin
          chk("evt_data_o", evt_data_o, sb[0]);
          if (evt_ready_i) mon_tmp = sb.pop_front();
        end
      end
    end
  end

  initial begin
    int t;
    system1000_rstn = 1'b1;
    sum_valid_i = 1'b0; sum_i = '0; evt_ready_i = 1'b0;
    thr_hi_i = 8'sd10; thr_lo_i = -8'sd10; hold_i = 4'd2;
    #2;
    do_reset();

    // Rising with hold 2, then aborted and completed falling
    step(1, 48, 0);
    step(1, 48, 0);
    chk("dir_avg12", {8'h00, avg_o}, 16'h000C);
    chk("dir_rise_evt", evt_data_o, 16'h810C);
    step(1, -48, 0);
    step(1, 40, 0);
    step(1, -48, 0);
    step(1, -48, 0);
    chk("dir_low", {14'h0, state_o}, 16'h0000);

    // Negative rounding
    step(1, -3, 0);
    chk("dir_avg_m1", {8'h00, avg_o}, 16'h00FF);
    step(1, -128, 0);
    chk("dir_avg_m32", {8'h00, avg_o}, 16'h00E0);

    // Fill queue, drop the fifth, then push while popping from full
    hold_i = 4'd0;
    step(1, 48, 0);
    step(1, -48, 0);
    step(1, 48, 0);
    step(0, 0, 0);
    chk("dir_overflow", {15'h0, overflow_o}, 16'h0001);
    step(1, -48, 1);
    step(0, 0, 0);
    drain();

    // Reset in HIGH with three queued events
    step(1, 48, 0);
    step(1, -48, 0);
    step(1, 48, 0);
    chk("dir_high_before_rst", {14'h0, state_o}, 16'h0002);
    do_reset();

    // Timestamp restarts at 0, then wraps: 130th sample carries ts 1
    hold_i = 4'd0;
    step(1, 48, 0);
    chk("dir_ts0_evt", evt_data_o, 16'h800C);
    drain();
    for (int i = 0; i < 128; i++) step(1, 0, 1);
    step(1, -48, 0);
    chk("dir_ts_wrap_evt", evt_data_o, 16'h01F4);
    drain();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      if (i % 60 == 0) begin
        t = $urandom_range(0, 40);
        thr_hi_i = 8'(t - 20);
        t = t - 20 - int'($urandom_range(0, 30));
        thr_lo_i = 8'(t);
        hold_i   = 4'($urandom_range(0, 4));
      end
      step($urandom_range(0, 9) < 7, int'($urandom_range(0, 255)) - 128,
           $urandom_range(0, 2) != 0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
